nic8_fetch: RTL and testbench
=============================

Name: nic8_fetch

Overview:
- Instruction-fetch stage of the nic8 CPU. Sits directly upstream of the execute datapath and directly downstream of the 2 KB program ROM.
- Owns the program counter and drives the ROM address, output-enable and chip-enable pins. Latches the opcode and an optional immediate byte from the ROM data bus.
- Hands each decoded instruction to execute through a valid/ready handshake, and accepts jump and halt requests back from execute.

Parameters:
- PC_W, 8, program-counter width; only the low 256 ROM bytes are used.
- ADDR_W, 11, ROM address width; bits above PC_W are driven 0.
- IMM_BIT, 7, opcode bit that marks a following immediate byte.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- CLK1 input 1 system clock; all state changes on the rising edge.
- CLRB1 input 1 reset, asynchronous, active-low.
- rom_addr output ADDR_W ROM address, equal to {0, pc}.
- rom_ceb output 1 ROM chip enable, active-low.
- rom_oeb output 1 ROM output enable, active-low.
- rom_data input 8 ROM data bus (the ROM's IO pins).
- pc output PC_W current program counter.
- ir output 8 instruction register.
- imm output 8 immediate register.
- exec_valid output 1 ir/imm hold an instruction for execute.
- exec_ready input 1 execute accepts the instruction this cycle.
- jump_en input 1 load jump_addr into pc on handshake.
- jump_addr input PC_W jump target.
- halt_req input 1 enter HALT on handshake.
- halted output 1 fetch stopped.

Behaviour:
- Reset (CLRB1 low, asynchronous): state=FETCH, pc=RESET_PC, ir=0, imm=0.
  - During reset: exec_valid=0, halted=0, rom_ceb=1, rom_oeb=1.
  - Reset overrides every state, including mid-instruction and HALT.
- States: FETCH, IMM, EXEC, HALT.
- rom_ceb and rom_oeb are combinational:
  - Both 0 in FETCH and IMM when CLRB1=1.
  - Both 1 in EXEC, HALT and during reset.
- exec_valid = (state==EXEC). halted = (state==HALT). Both are combinational from the state register.
- FETCH, on each edge:
  - ir <= rom_data; pc <= pc+1.
  - Next state is IMM if rom_data[IMM_BIT]=1, else EXEC.
- IMM, on each edge: imm <= rom_data; pc <= pc+1; next state EXEC.
- EXEC without handshake (exec_ready=0): hold state, pc, ir and imm unchanged.
- EXEC with handshake (exec_ready=1):
  - If jump_en=1, pc <= jump_addr; otherwise pc is unchanged, since it already points past the instruction.
  - Next state is HALT if halt_req=1, else FETCH.
  - If jump_en and halt_req are both 1, the jump is applied and then the block halts; pc shows jump_addr.
- jump_en and halt_req are ignored in every cycle without a handshake.
- HALT: terminal state; all registers hold. Only reset exits.
- Arithmetic: pc increments modulo 2^PC_W, so 0xFF+1 wraps to 0x00. An immediate byte fetched after an opcode at 0xFF is read from 0x00.
- imm keeps its previous value across non-immediate instructions. It is not cleared.
- Latency:
  - Non-immediate instruction: 2 cycles (FETCH, EXEC).
  - Immediate instruction: 3 cycles (FETCH, IMM, EXEC).
  - Each cycle of exec_ready=0 adds one cycle.
- exec_valid rises the cycle after the last ROM byte is latched.
- rom_data is sampled only in FETCH and IMM. Its value in other states is don't-care, including 'z.

Decomposition:
- Package nic8_pkg holds:
  - enum fetch_state_t {FETCH, IMM, EXEC, HALT};
  - constants IMM_BIT and RESET_PC;
  - the ROM pin polarity constants, shared with the ROM and RAM chip models.
- One sub-module, nic8_pc_counter: PC_W-bit register with async clear to RESET_PC, synchronous load (jump) and increment. Load has priority over increment.
- The state machine and ir/imm registers stay in nic8_fetch.

Test Plan:
- Reset: hold CLRB1=0 for 3 cycles, then release.
  - While low: pc=0x00, exec_valid=0, halted=0, rom_ceb=rom_oeb=1.
  - After release: rom_addr=0x000, rom_ceb=rom_oeb=0.
- Sequence: ROM[0..3]={0x01,0x85,0x42,0x02}, exec_ready=1. Per edge:
  - Edge 1: ir=0x01, pc=1.
  - Edge 2: consumes 0x01.
  - Edge 3: ir=0x85, pc=2.
  - Edge 4: imm=0x42, pc=3.
  - During the next cycle: exec_valid=1 with ir=0x85, imm=0x42.
- Stall: during EXEC of 0x01, hold exec_ready=0 for 3 cycles.
  - Required: exec_valid stays 1; pc, ir and imm are stable; rom_oeb=1.
  - After ready rises: exactly one handshake occurs, then FETCH at pc=1.
- Jump: during EXEC, jump_en=1, jump_addr=0x10, ROM[0x10]=0x07.
  - Next cycle: rom_addr=0x010.
  - Then: ir=0x07, pc=0x11.
  - jump_en=1 with exec_ready=0 leaves pc unchanged.
- Wrap: set pc=0xFF via jump, ROM[0xFF]=0x80, ROM[0x00]=0x33.
  - Required: ir=0x80, then imm=0x33, pc=0x01.
- Halt: halt_req=1 and jump_en=1 with jump_addr=0x20 on a handshake.
  - Required: halted=1, pc=0x20, rom_ceb=1; holds for 10 cycles.
  - Pulse CLRB1 low mid-HALT: state=FETCH, pc=0x00, halted=0.

Source files
------------

// File: rtl/nic8_pkg.sv
// Shared types and constants for the nic8 fetch stage and its ROM/RAM chip models.
package nic8_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    IMM   = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int         IMM_BIT  = 7;
  localparam logic [7:0] RESET_PC = 8'h00;

  // Memory chip pins (ceb/oeb) are active-low.
  localparam logic ROM_EN_ACTIVE = 1'b0;
  localparam logic ROM_EN_IDLE   = 1'b1;

endpackage

// File: rtl/nic8_pc_counter.sv
// Program counter: async clear to the reset vector, synchronous load and increment.
module nic8_pc_counter
  import nic8_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VAL = PC_W'(RESET_PC)
) (
  input  logic            CLK1,
  input  logic            CLRB1,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // A jump wins over a simultaneous increment; the increment wraps modulo 2^PC_W.
  always_ff @(posedge CLK1 or negedge CLRB1) begin
    if (!CLRB1) begin
      pc <= RESET_VAL;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/nic8_fetch.sv
// nic8 instruction fetch: drives the program ROM, latches opcode/immediate and
// hands instructions to execute over a valid/ready handshake.
module nic8_fetch
  import nic8_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int ADDR_W = 11
) (
  input  logic              CLK1,
  input  logic              CLRB1,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ceb,
  output logic              rom_oeb,
  input  logic [7:0]        rom_data,
  output logic [PC_W-1:0]   pc,
  output logic [7:0]        ir,
  output logic [7:0]        imm,
  output logic              exec_valid,
  input  logic              exec_ready,
  input  logic              jump_en,
  input  logic [PC_W-1:0]   jump_addr,
  input  logic              halt_req,
  output logic              halted
);

  fetch_state_t state_reg;
  logic         rom_cycle;
  logic         handshake;
  logic         pc_load;
  logic         pc_inc;

  assign rom_cycle  = (state_reg == FETCH) || (state_reg == IMM);
  assign handshake  = (state_reg == EXEC) && exec_ready;
  assign pc_load    = handshake && jump_en;
  assign pc_inc     = rom_cycle;

  assign exec_valid = (state_reg == EXEC);
  assign halted     = (state_reg == HALT);

  // The async reset forces FETCH, so the enables must also be gated by CLRB1
  // to keep the ROM deselected while reset is held.
  assign rom_ceb  = (rom_cycle && CLRB1) ? ROM_EN_ACTIVE : ROM_EN_IDLE;
  assign rom_oeb  = (rom_cycle && CLRB1) ? ROM_EN_ACTIVE : ROM_EN_IDLE;
  assign rom_addr = {{(ADDR_W-PC_W){1'b0}}, pc};

  nic8_pc_counter #(
    .PC_W      (PC_W),
    .RESET_VAL (PC_W'(RESET_PC))
  ) u_pc (
    .CLK1     (CLK1),
    .CLRB1    (CLRB1),
    .load     (pc_load),
    .load_val (jump_addr),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge CLK1 or negedge CLRB1) begin
    if (!CLRB1) begin
      state_reg <= FETCH;
      ir        <= 8'h00;
      imm       <= 8'h00;
    end else begin
      case (state_reg)
        FETCH: begin
          ir        <= rom_data;
          state_reg <= rom_data[IMM_BIT] ? IMM : EXEC;
        end
        IMM: begin
          imm       <= rom_data;
          state_reg <= EXEC;
        end
        EXEC: begin
          if (exec_ready) begin
            state_reg <= halt_req ? HALT : FETCH;
          end
        end
        HALT: begin
          state_reg <= HALT;
        end
        default: begin
          state_reg <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nic8_fetch.sv
// Directed bench for nic8_fetch: scoreboard checks every handshake, direct checks cover pins and boundaries.
module tb_nic8_fetch;

  logic        CLK1;
  logic        CLRB1;
  logic [10:0] rom_addr;
  logic        rom_ceb;
  logic        rom_oeb;
  logic [7:0]  rom_data;
  logic [7:0]  pc;
  logic [7:0]  ir;
  logic [7:0]  imm;
  logic        exec_valid;
  logic        exec_ready;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        halt_req;
  logic        halted;

  logic [7:0] rom_mem [0:2047];

  typedef struct packed {
    logic [7:0] ir;
    logic [7:0] imm;
    logic [7:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt;
  int   total_cnt;
  int   hs_cnt;

  nic8_fetch dut (
    .CLK1       (CLK1),
    .CLRB1      (CLRB1),
    .rom_addr   (rom_addr),
    .rom_ceb    (rom_ceb),
    .rom_oeb    (rom_oeb),
    .rom_data   (rom_data),
    .pc         (pc),
    .ir         (ir),
    .imm        (imm),
    .exec_valid (exec_valid),
    .exec_ready (exec_ready),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .halt_req   (halt_req),
    .halted     (halted)
  );

  // ROM model drives a recognisable junk value when deselected.
  assign rom_data = (rom_ceb == 1'b0 && rom_oeb == 1'b0) ? rom_mem[rom_addr] : 8'hEE;

  initial CLK1 = 1'b0;
  always #5 CLK1 = ~CLK1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK1);
    #1;
  endtask

  task automatic samp();
    @(negedge CLK1);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK1);
      if (exec_valid && exec_ready) begin
        hs_cnt++;
        $display("handshake %0d: ir=0x%02h imm=0x%02h pc=0x%02h jump=%0b halt=%0b",
                 hs_cnt, ir, imm, pc, jump_en, halt_req);
        if (exp_q.size() == 0) begin
          check("hs_unexpected", 32'(hs_cnt), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("hs_ir",  32'(ir),  32'(e.ir));
          check("hs_imm", 32'(imm), 32'(e.imm));
          check("hs_pc",  32'(pc),  32'(e.pc));
        end
      end
    end
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    hs_cnt     = 0;
    CLRB1      = 1'b0;
    exec_ready = 1'b0;
    jump_en    = 1'b0;
    jump_addr  = 8'h00;
    halt_req   = 1'b0;
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'h00;
    rom_mem[0]     = 8'h01;
    rom_mem[1]     = 8'h85;
    rom_mem[2]     = 8'h42;
    rom_mem[3]     = 8'h02;
    rom_mem[11'h10] = 8'h07;
    rom_mem[11'hFF] = 8'h80;

    fork
      monitor();
    join_none

    // Reset held for three cycles
    repeat (3) begin
      samp();
      check("rst_pc",     32'(pc),         32'h00);
      check("rst_valid",  32'(exec_valid), 32'h0);
      check("rst_halted", 32'(halted),     32'h0);
      check("rst_ceb",    32'(rom_ceb),    32'h1);
      check("rst_oeb",    32'(rom_oeb),    32'h1);
    end
    step();
    CLRB1 = 1'b1;
    samp();
    check("rel_addr",  32'(rom_addr),   32'h000);
    check("rel_ceb",   32'(rom_ceb),    32'h0);
    check("rel_oeb",   32'(rom_oeb),    32'h0);
    check("rel_valid", 32'(exec_valid), 32'h0);
    check("rel_ir",    32'(ir),         32'h00);

    // 0x01 fetched, then stalled for three cycles
    step();
    exp_q.push_back('{ir: 8'h01, imm: 8'h00, pc: 8'h01});
    for (int i = 0; i < 3; i++) begin
      samp();
      check("stall_valid", 32'(exec_valid), 32'h1);
      check("stall_pc",    32'(pc),         32'h01);
      check("stall_ir",    32'(ir),         32'h01);
      check("stall_imm",   32'(imm),        32'h00);
      check("stall_oeb",   32'(rom_oeb),    32'h1);
      step();
    end
    exec_ready = 1'b1;
    samp();
    check("hs1_valid", 32'(exec_valid), 32'h1);
    step();
    samp();
    check("refetch_valid", 32'(exec_valid), 32'h0);
    check("refetch_pc",    32'(pc),         32'h01);
    check("refetch_addr",  32'(rom_addr),   32'h001);
    check("refetch_oeb",   32'(rom_oeb),    32'h0);

    // Immediate instruction 0x85 0x42
    step();
    samp();
    check("op85_ir",    32'(ir),         32'h85);
    check("op85_pc",    32'(pc),         32'h02);
    check("op85_valid", 32'(exec_valid), 32'h0);
    step();
    exp_q.push_back('{ir: 8'h85, imm: 8'h42, pc: 8'h03});
    samp();
    check("op85_exec_valid", 32'(exec_valid), 32'h1);
    step();

    // 0x02 with a jump request that must be ignored while not ready
    step();
    exec_ready = 1'b0;
    jump_en    = 1'b1;
    jump_addr  = 8'h10;
    exp_q.push_back('{ir: 8'h02, imm: 8'h42, pc: 8'h04});
    samp();
    check("op02_ir", 32'(ir), 32'h02);
    check("op02_pc", 32'(pc), 32'h04);
    step();
    exec_ready = 1'b1;
    samp();
    check("nojump_pc",    32'(pc),         32'h04);
    check("nojump_valid", 32'(exec_valid), 32'h1);
    step();
    jump_en = 1'b0;
    samp();
    check("jump_addr_pin", 32'(rom_addr), 32'h010);
    check("jump_pc",       32'(pc),       32'h10);
    step();
    exp_q.push_back('{ir: 8'h07, imm: 8'h42, pc: 8'h11});
    jump_en   = 1'b1;
    jump_addr = 8'hFF;
    rom_mem[0] = 8'h33;
    samp();
    check("op07_ir", 32'(ir), 32'h07);
    check("op07_pc", 32'(pc), 32'h11);
    step();
    jump_en = 1'b0;

    // Immediate opcode at 0xFF reads its operand from 0x00
    samp();
    check("wrap_addr", 32'(rom_addr), 32'h0FF);
    step();
    samp();
    check("wrap_ir", 32'(ir), 32'h80);
    check("wrap_pc", 32'(pc), 32'h00);
    step();
    exp_q.push_back('{ir: 8'h80, imm: 8'h33, pc: 8'h01});
    jump_en   = 1'b1;
    jump_addr = 8'h20;
    halt_req  = 1'b1;
    samp();
    check("wrap_imm", 32'(imm), 32'h33);
    check("wrap_pc2", 32'(pc),  32'h01);
    step();

    // Jump+halt together: halted at the jump target, requests now ignored
    jump_addr = 8'h55;
    for (int i = 0; i < 10; i++) begin
      samp();
      check("halt_flag",  32'(halted),     32'h1);
      check("halt_pc",    32'(pc),         32'h20);
      check("halt_ceb",   32'(rom_ceb),    32'h1);
      check("halt_valid", 32'(exec_valid), 32'h0);
      step();
    end

    // Asynchronous reset pulse mid-HALT
    CLRB1 = 1'b0;
    #1;
    check("hrst_pc",     32'(pc),         32'h00);
    check("hrst_halted", 32'(halted),     32'h0);
    check("hrst_valid",  32'(exec_valid), 32'h0);
    check("hrst_imm",    32'(imm),        32'h00);
    check("hrst_ceb",    32'(rom_ceb),    32'h1);
    step();
    CLRB1      = 1'b1;
    exec_ready = 1'b0;
    jump_en    = 1'b0;
    halt_req   = 1'b0;
    samp();
    check("post_halted", 32'(halted),   32'h0);
    check("post_ceb",    32'(rom_ceb),  32'h0);
    check("post_addr",   32'(rom_addr), 32'h000);
    step();
    samp();
    check("post_ir",    32'(ir),         32'h33);
    check("post_valid", 32'(exec_valid), 32'h1);

    check("sb_empty", 32'(exp_q.size()), 32'h0);
    check("hs_count", 32'(hs_cnt),       32'd5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
